dm_cache_ctrl: RTL and testbench
================================

Name: dm_cache_ctrl

Overview:
- Parametrised direct-mapped, multi-word-line cache with its own refill/write-through controller.
- Sits between the pipeline memory stage and backing data memory.
- Adds line refill over a memory handshake, write-through stores, stall generation, a sequenced full flush and reset-cleared valid bits.

Parameters:
- INDEX_WIDTH, 4, log2 of line count.
- LINE_WORDS, 4, 32-bit words per line; power of two, at least 2.
- DATA_WIDTH, 32, word width; fixed at 32 for this generation.

Ports:
- iCLK  in  1  sole clock; all state updates on posedge.
- iRSTn  in  1  asynchronous, active-low reset.
- iReq  in  1  CPU access request; address and data held stable while oStall=1.
- iWE  in  1  1=store, 0=load.
- iAddr  in  32  byte address; bits [1:0] ignored.
- iWData  in  32  store data.
- oRData  out  32  load data; valid when iReq & ~iWE & ~oStall.
- oStall  out  1  freeze pipeline.
- iFlush  in  1  single-cycle pulse: invalidate all lines.
- oFlushBusy  out  1  flush sweep in progress.
- oMemReq  out  1  memory request.
- oMemWE  out  1  memory write.
- oMemAddr  out  32  word-aligned memory address.
- oMemWData  out  32  memory write data.
- iMemAck  in  1  memory accepted/completed the current beat.
- iMemRData  in  32  read data; valid with iMemAck on reads.

Behaviour:
- Address split: offset = iAddr[OFF+1:2] with OFF=log2(LINE_WORDS); index = next INDEX_WIDTH bits; tag = remaining upper bits (default 24). hit = valid[index] & (tag match).
- Reset: all valid=0, state IDLE, word counter 0, flush pointer 0, flush-pending 0, oMemReq/oMemWE=0, oMemAddr/oMemWData=0, oFlushBusy=0. Data/tag arrays are not reset.
- FSM states: IDLE, REFILL, WRITE, FLUSH.
- IDLE, load hit: oRData combinational from data[index][offset]; oStall=0; zero-cycle latency.
- IDLE, load miss:
  - oStall=1; go to REFILL.
  - Clear valid[index] immediately so a partial line can never hit.
- REFILL:
  - oMemReq=1, oMemWE=0, oMemAddr = {tag,index,k,2'b00} for k=0..LINE_WORDS-1.
  - Each posedge with iMemAck writes iMemRData into word k; k increments and oMemReq stays high.
  - Ack on the last word: write tag, set valid, go to IDLE. The same load then hits on the next cycle.
  - Minimum refill is LINE_WORDS cycles with zero-wait memory.
- IDLE, store:
  - oStall=1; go to WRITE.
  - oMemReq=1, oMemWE=1, oMemAddr = iAddr with bits [1:0] zeroed, oMemWData = iWData.
- WRITE, on iMemAck:
  - If hit, also update data[index][offset].
  - Miss is no-allocate.
  - Return to IDLE; oStall drops in that cycle.
- Handshake rule: oMemReq/oMemAddr/oMemWData/oMemWE are stable until the posedge where iMemAck=1. Ack in the same cycle as first assertion is legal.
- iFlush in IDLE: go to FLUSH, which clears valid[p] for p=0..2^INDEX_WIDTH-1, one per cycle.
  - oFlushBusy=1 and oStall=iReq for the whole sweep (2^INDEX_WIDTH cycles); then return to IDLE.
- iFlush during REFILL or WRITE: latch into flush-pending; enter FLUSH immediately after that transaction completes.
- iFlush during FLUSH: ignored.
- iFlush and iReq in the same IDLE cycle: flush wins; the request stalls and is serviced after the sweep, and will miss.
- Reset mid-REFILL/WRITE:
  - Transaction is abandoned; oMemReq drops asynchronously.
  - All valid bits clear; the partial line is discarded.

Optional Feature:
- Macro CACHE_STATS_EN.
- Defined: adds outputs oHitCount[31:0] and oMissCount[31:0], wrapping, reset to 0.
  - Hit counts once per load completed in IDLE without refill.
  - Miss counts once per IDLE->REFILL transition.
  - Stores are not counted.
- Undefined: ports and counters absent; behaviour otherwise identical.

Decomposition:
- Package cache_pkg:
  - State enum cache_state_t {IDLE, REFILL, WRITE, FLUSH}.
  - Helper functions deriving OFF and tag width from parameters.
  - Address-field struct typedef.
- One sub-module, cache_line_ram: tag/valid/data arrays with combinational read, synchronous word write, per-line valid clear, and async valid clear on reset.

Test Plan:
- Cold load miss then hit (iMemAck always 1):
  - Reset, load 0x100 -> memory reads 0x100, 0x104, 0x108, 0x10C over 4 cycles.
  - Next cycle oRData = mem[0x100].
  - Load 0x104 -> oStall=0 with mem[0x104].
- Conflict miss: after the first test, load 0x500 (same index 0, different tag) -> full refill from 0x500; then load 0x100 misses again.
- Write-through:
  - Store 0xDEADBEEF to 0x104 (hit) -> one memory write at 0x104; load 0x104 returns 0xDEADBEEF with no stall.
  - Store to 0x2000 (miss) -> memory write only; load 0x2000 then misses.
- Flush: fill index 0 and index 3, pulse iFlush -> oFlushBusy high exactly 16 cycles; both addresses then miss.
- Waited memory plus reset:
  - iMemAck delayed 3 cycles per beat -> refill takes 16 cycles with address stable while waiting.
  - Second run: assert iRSTn=0 after word 1 -> oMemReq falls immediately; after release, a load to that line misses.
- Deferred flush: pulse iFlush during REFILL beat 2 -> refill completes, then a 16-cycle FLUSH; the refilled line is invalid afterwards.

Source files
------------

// File: rtl/dm_cache_ctrl_pkg.sv
// Shared types and address helpers for the direct-mapped cache controller.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package cache_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REFILL,
        WRITE,
        FLUSH
    } cache_state_t;

    // Word-offset field width inside a line.
    function automatic int off_bits(input int line_words);
        return $clog2(line_words);
    endfunction

    // Tag width left over once byte, offset and index bits are removed.
    function automatic int tag_bits(input int index_width, input int line_words);
        return 32 - 2 - $clog2(line_words) - index_width;
    endfunction

    // Fields are 32 bits wide so one struct serves every geometry;
    // users keep only the low bits they need.
    typedef struct packed {
        logic [31:0] tag;
        logic [31:0] index;
        logic [31:0] offset;
    } addr_fields_t;

    function automatic addr_fields_t split_addr(input logic [31:0] addr,
                                                input int index_width,
                                                input int line_words);
        addr_fields_t f;
        int           off;
        off      = $clog2(line_words);
        f.offset = (addr >> 2) & ((32'd1 << off) - 32'd1);
        f.index  = (addr >> (2 + off)) & ((32'd1 << index_width) - 32'd1);
        f.tag    = addr >> (2 + off + index_width);
        return f;
    endfunction

endpackage

// File: rtl/dm_cache_ctrl_if.sv
// CPU-side and memory-side bus bundle of the cache controller (CACHE_STATS_EN adds counters).
// Latency: n/a (wires only).
// Backpressure: oStall to the CPU, iMemAck from memory.
interface dm_cache_ctrl_if;
    logic        iReq;
    logic        iWE;
    logic [31:0] iAddr;
    logic [31:0] iWData;
    logic [31:0] oRData;
    logic        oStall;
    logic        iFlush;
    logic        oFlushBusy;
    logic        oMemReq;
    logic        oMemWE;
    logic [31:0] oMemAddr;
    logic [31:0] oMemWData;
    logic        iMemAck;
    logic [31:0] iMemRData;
`ifdef CACHE_STATS_EN
    logic [31:0] oHitCount;
    logic [31:0] oMissCount;
`endif

    // Cache side.
    modport slave (
        input  iReq, iWE, iAddr, iWData, iFlush, iMemAck, iMemRData,
        output oRData, oStall, oFlushBusy, oMemReq, oMemWE, oMemAddr, oMemWData
`ifdef CACHE_STATS_EN
        , output oHitCount, oMissCount
`endif
    );

    // Pipeline / memory side.
    modport master (
        output iReq, iWE, iAddr, iWData, iFlush, iMemAck, iMemRData,
        input  oRData, oStall, oFlushBusy, oMemReq, oMemWE, oMemAddr, oMemWData
`ifdef CACHE_STATS_EN
        , input oHitCount, oMissCount
`endif
    );
endinterface

// File: rtl/dm_cache_ctrl_line_ram.sv
// Tag/valid/data storage: combinational read, synchronous word and tag write, per-line invalidate.
// Latency: read 0 cycles, writes visible after the next posedge.
// Backpressure: none; valid bits clear asynchronously on reset.
module cache_line_ram #(
    parameter int INDEX_WIDTH = 4,
    parameter int LINE_WORDS  = 4,
    parameter int TAG_W       = 24,
    parameter int DATA_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [INDEX_WIDTH-1:0]        rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_offset,
    output logic [TAG_W-1:0]              rd_tag,
    output logic                          rd_valid,
    output logic [DATA_WIDTH-1:0]         rd_data,
    input  logic                          word_we,
    input  logic [INDEX_WIDTH-1:0]        word_index,
    input  logic [$clog2(LINE_WORDS)-1:0] word_offset,
    input  logic [DATA_WIDTH-1:0]         word_data,
    input  logic                          line_we,
    input  logic [INDEX_WIDTH-1:0]        line_index,
    input  logic [TAG_W-1:0]              line_tag,
    input  logic                          inval_en,
    input  logic [INDEX_WIDTH-1:0]        inval_index
);
    localparam int LINES = 1 << INDEX_WIDTH;

    logic [DATA_WIDTH-1:0] data_mem [LINES][LINE_WORDS];
    logic [TAG_W-1:0]      tag_mem  [LINES];
    logic [LINES-1:0]      valid;

    assign rd_tag   = tag_mem[rd_index];
    assign rd_valid = valid[rd_index];
    assign rd_data  = data_mem[rd_index][rd_offset];

    // Valid bits: reset clears all; a line fill sets, invalidate clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (inval_en) valid[inval_index] <= 1'b0;
            if (line_we)  valid[line_index]  <= 1'b1;
        end
    end

    // Data and tag arrays are storage only, never reset.
    always_ff @(posedge clk) begin
        if (word_we) data_mem[word_index][word_offset] <= word_data;
        if (line_we) tag_mem[line_index] <= line_tag;
    end
endmodule

// File: rtl/dm_cache_ctrl.sv
// Direct-mapped write-through cache with line refill and full flush sweep; CACHE_STATS_EN adds hit/miss counters.
// Latency: load hit 0 cycles; miss LINE_WORDS beats min; store one memory beat; flush 2^INDEX_WIDTH cycles.
// Backpressure: oStall holds the pipeline; memory outputs held until iMemAck.
module dm_cache_ctrl
    import cache_pkg::*;
#(
    parameter int INDEX_WIDTH = 4,
    parameter int LINE_WORDS  = 4,
    parameter int DATA_WIDTH  = 32
) (
    input logic            iCLK,
    input logic            iRSTn,
    dm_cache_ctrl_if.slave bus
);
    localparam int OFF   = off_bits(LINE_WORDS);
    localparam int TAG_W = tag_bits(INDEX_WIDTH, LINE_WORDS);
    localparam logic [OFF-1:0] LAST_WORD = OFF'(LINE_WORDS - 1);

    cache_state_t           state;
    logic [OFF-1:0]         word_cnt, next_cnt;
    logic [INDEX_WIDTH-1:0] flush_ptr;
    logic                   flush_pend, flush_busy;
    logic                   mem_req, mem_we;
    logic [31:0]            mem_addr, mem_wdata;

    addr_fields_t           cpu_f, fill_f;
    logic [INDEX_WIDTH-1:0] cpu_index, fill_index;
    logic [OFF-1:0]         cpu_off;
    logic [TAG_W-1:0]       cpu_tag, fill_tag, rd_tag;
    logic                   rd_valid, hit, stall;
    logic [DATA_WIDTH-1:0]  rd_data;

    logic                   word_we, line_we, inval_en;
    logic [INDEX_WIDTH-1:0] word_index, inval_index;
    logic [OFF-1:0]         word_offset;
    logic [DATA_WIDTH-1:0]  word_data;

    // CPU fields come from the live address; refill fields from the held memory address.
    assign cpu_f      = split_addr(bus.iAddr, INDEX_WIDTH, LINE_WORDS);
    assign fill_f     = split_addr(mem_addr, INDEX_WIDTH, LINE_WORDS);
    assign cpu_index  = cpu_f.index[INDEX_WIDTH-1:0];
    assign cpu_off    = cpu_f.offset[OFF-1:0];
    assign cpu_tag    = cpu_f.tag[TAG_W-1:0];
    assign fill_index = fill_f.index[INDEX_WIDTH-1:0];
    assign fill_tag   = fill_f.tag[TAG_W-1:0];
    assign next_cnt   = word_cnt + 1'b1;

    logic unused_fields;
    assign unused_fields = ^{cpu_f.tag[31:TAG_W], cpu_f.index[31:INDEX_WIDTH], cpu_f.offset[31:OFF],
                             fill_f.tag[31:TAG_W], fill_f.index[31:INDEX_WIDTH], fill_f.offset};

    cache_line_ram #(
        .INDEX_WIDTH(INDEX_WIDTH), .LINE_WORDS(LINE_WORDS), .TAG_W(TAG_W), .DATA_WIDTH(DATA_WIDTH)
    ) u_ram (
        .clk(iCLK), .rst_n(iRSTn),
        .rd_index(cpu_index), .rd_offset(cpu_off), .rd_tag(rd_tag), .rd_valid(rd_valid), .rd_data(rd_data),
        .word_we(word_we), .word_index(word_index), .word_offset(word_offset), .word_data(word_data),
        .line_we(line_we), .line_index(fill_index), .line_tag(fill_tag),
        .inval_en(inval_en), .inval_index(inval_index)
    );

    assign hit = rd_valid && (rd_tag == cpu_tag);

    // Per-state stall and array write/invalidate strobes.
    always_comb begin
        stall       = 1'b0;
        word_we     = 1'b0;
        word_index  = cpu_index;
        word_offset = cpu_off;
        word_data   = mem_wdata;
        line_we     = 1'b0;
        inval_en    = 1'b0;
        inval_index = cpu_index;
        case (state)
            IDLE: begin
                stall    = bus.iReq & (bus.iFlush | bus.iWE | ~hit);
                // A miss drops the line now so a half-filled line can never hit.
                inval_en = bus.iReq & ~bus.iFlush & ~bus.iWE & ~hit;
            end
            REFILL: begin
                stall       = 1'b1;
                word_we     = bus.iMemAck;
                word_index  = fill_index;
                word_offset = word_cnt;
                word_data   = bus.iMemRData;
                line_we     = bus.iMemAck & (word_cnt == LAST_WORD);
            end
            WRITE: begin
                // The store retires on the ack edge, so the pipeline may advance with it.
                stall   = ~bus.iMemAck;
                word_we = bus.iMemAck & hit;
            end
            FLUSH: begin
                stall       = bus.iReq;
                inval_en    = 1'b1;
                inval_index = flush_ptr;
            end
            default: stall = 1'b0;
        endcase
    end

    // Controller FSM with registered memory-side outputs.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state      <= IDLE;
            word_cnt   <= '0;
            flush_ptr  <= '0;
            flush_pend <= 1'b0;
            flush_busy <= 1'b0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.iFlush) begin
                        state      <= FLUSH;
                        flush_ptr  <= '0;
                        flush_busy <= 1'b1;
                    end else if (bus.iReq && bus.iWE) begin
                        state     <= WRITE;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b1;
                        mem_addr  <= {bus.iAddr[31:2], 2'b00};
                        mem_wdata <= bus.iWData;
                    end else if (bus.iReq && !hit) begin
                        state    <= REFILL;
                        mem_req  <= 1'b1;
                        mem_we   <= 1'b0;
                        mem_addr <= {bus.iAddr[31:OFF+2], {OFF{1'b0}}, 2'b00};
                        word_cnt <= '0;
                    end
                end
                REFILL, WRITE: begin
                    if (bus.iFlush) flush_pend <= 1'b1;
                    if (bus.iMemAck) begin
                        if (state == REFILL && word_cnt != LAST_WORD) begin
                            word_cnt <= next_cnt;
                            mem_addr <= {mem_addr[31:OFF+2], next_cnt, 2'b00};
                        end else begin
                            mem_req <= 1'b0;
                            mem_we  <= 1'b0;
                            if (flush_pend || bus.iFlush) begin
                                state      <= FLUSH;
                                flush_ptr  <= '0;
                                flush_busy <= 1'b1;
                                flush_pend <= 1'b0;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                end
                FLUSH: begin
                    flush_ptr <= flush_ptr + 1'b1;
                    if (&flush_ptr) begin
                        state      <= IDLE;
                        flush_busy <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef CACHE_STATS_EN
    logic        after_fill;
    logic [31:0] hit_cnt, miss_cnt;

    // The completion cycle right after a refill is the missed load, not a new hit.
    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            after_fill <= 1'b0;
            hit_cnt    <= '0;
            miss_cnt   <= '0;
        end else begin
            after_fill <= (state == REFILL) && bus.iMemAck && (word_cnt == LAST_WORD)
                          && !(flush_pend || bus.iFlush);
            if (state == IDLE && bus.iReq && !bus.iFlush && !bus.iWE) begin
                if (hit) begin
                    if (!after_fill) hit_cnt <= hit_cnt + 1'b1;
                end else begin
                    miss_cnt <= miss_cnt + 1'b1;
                end
            end
        end
    end

    assign bus.oHitCount  = hit_cnt;
    assign bus.oMissCount = miss_cnt;
`endif

    assign bus.oRData     = rd_data;
    assign bus.oStall     = stall;
    assign bus.oFlushBusy = flush_busy;
    assign bus.oMemReq    = mem_req;
    assign bus.oMemWE     = mem_we;
    assign bus.oMemAddr   = mem_addr;
    assign bus.oMemWData  = mem_wdata;
endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Self-checking bench for dm_cache_ctrl: directed scenarios then random loads/stores/flushes.
// Latency: n/a.
// Backpressure: a memory responder with programmable ack delay.
module tb_dm_cache_ctrl;
    localparam int IW    = 4;
    localparam int LW    = 4;
    localparam int LINES = 1 << IW;
    localparam int OFFB  = $clog2(LW);
    localparam int BUDGET = 300;

    logic iCLK, iRSTn;
    dm_cache_ctrl_if bus_if ();

    dm_cache_ctrl #(.INDEX_WIDTH(IW), .LINE_WORDS(LW), .DATA_WIDTH(32)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn), .bus(bus_if)
    );

    initial begin
        iCLK = 1'b0;
        forever #5 iCLK = ~iCLK;
    end

    int checks = 0;
    int errors = 0;

    // Memory model and beat log.
    logic [31:0] mem [bit [31:0]];
    logic [31:0] log_addr [$];
    bit          log_we [$];
    logic [31:0] log_wdat [$];
    int          ack_delay = 0;
    int          wait_cnt = 0;
    int          req_cycles = 0;
    bit          ack_drv = 0;
    bit          cap_vld = 0;
    logic [31:0] cap_addr, cap_wdata;
    bit          cap_we;

    // Cache contents model: which tag each line holds, if any.
    bit          mvalid [LINES];
    logic [31:0] mtag [LINES];
    int          exp_hits = 0;
    int          exp_miss = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic timeout(input string tag);
        checks++;
        errors++;
        $error("FAIL %s timed out", tag);
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        logic [31:0] v;
        if (mem.exists(a)) return mem[a];
        v = {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
        return v;
    endfunction

    function automatic int line_of(input logic [31:0] a);
        return int'((a >> (2 + OFFB)) % LINES);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + OFFB + IW);
    endfunction

    function automatic logic [31:0] base_of(input logic [31:0] a);
        return a & ~(32'(LW * 4) - 32'd1);
    endfunction

    task automatic flush_model();
        for (int i = 0; i < LINES; i++) mvalid[i] = 0;
    endtask

    task automatic clear_log();
        log_addr.delete();
        log_we.delete();
        log_wdat.delete();
        req_cycles = 0;
    endtask

    // One clock: go to the falling edge, retire the beat accepted at the
    // last rising edge, then decide this cycle's ack.
    task automatic cyc();
        @(negedge iCLK);
        if (!iRSTn) begin
            ack_drv  = 0;
            cap_vld  = 0;
            wait_cnt = 0;
        end else begin
            if (ack_drv && cap_vld) begin
                log_addr.push_back(cap_addr);
                log_we.push_back(cap_we);
                log_wdat.push_back(cap_wdata);
                if (cap_we) mem[cap_addr] = cap_wdata;
                cap_vld  = 0;
                wait_cnt = 0;
            end
            ack_drv = 0;
            if (bus_if.oMemReq) begin
                req_cycles++;
                if (cap_vld) begin
                    chk("mem_addr_stable", bus_if.oMemAddr, cap_addr);
                    chk("mem_wdata_stable", bus_if.oMemWData, cap_wdata);
                end else begin
                    cap_vld   = 1;
                    cap_addr  = bus_if.oMemAddr;
                    cap_we    = bus_if.oMemWE;
                    cap_wdata = bus_if.oMemWData;
                end
                if (wait_cnt >= ack_delay) begin
                    ack_drv = 1;
                    bus_if.iMemRData = mem_rd(bus_if.oMemAddr);
                end else begin
                    wait_cnt++;
                end
            end
        end
        bus_if.iMemAck = ack_drv;
    endtask

    // mode 0: plain load; 1: iFlush together with the request; 2: iFlush pulsed during the refill.
    task automatic do_load(input logic [31:0] a, input int mode);
        int          li, busy_n, nref;
        logic [31:0] t;
        bit          hit0, done;
        li = line_of(a);
        t  = tag_of(a);
        if (mode == 1) flush_model();
        hit0 = mvalid[li] && (mtag[li] == t);
        clear_log();
        busy_n = 0;
        bus_if.iReq   = 1;
        bus_if.iWE    = 0;
        bus_if.iAddr  = a;
        bus_if.iFlush = (mode == 1);
        #1;
        chk("ld_stall_first", bus_if.oStall, !hit0);
        done = !bus_if.oStall;
        for (int j = 0; j < BUDGET && !done; j++) begin
            cyc();
            bus_if.iFlush = (mode == 2 && j == 1);
            #1;
            if (bus_if.oFlushBusy) busy_n++;
            if (!bus_if.oStall) done = 1;
        end
        if (!done) timeout("ld_wait");
        chk("ld_rdata", bus_if.oRData, mem_rd({a[31:2], 2'b00}));
        cyc();
        bus_if.iReq = 0;
        nref = hit0 ? 0 : ((mode == 2) ? 2 : 1);
        chk("ld_beats", log_addr.size(), nref * LW);
        for (int i = 0; i < log_addr.size(); i++) begin
            chk("ld_beat_addr", log_addr[i], base_of(a) + 32'(4 * (i % LW)));
            chk("ld_beat_we", log_we[i], 0);
        end
        chk("ld_busy_cycles", busy_n, (mode != 0) ? LINES : 0);
        if (hit0) exp_hits++;
        exp_miss += nref;
        mvalid[li] = 1;
        mtag[li]   = t;
    endtask

    task automatic do_store(input logic [31:0] a, input logic [31:0] d);
        bit done;
        clear_log();
        bus_if.iReq   = 1;
        bus_if.iWE    = 1;
        bus_if.iAddr  = a;
        bus_if.iWData = d;
        bus_if.iFlush = 0;
        #1;
        chk("st_stall_first", bus_if.oStall, 1);
        done = 0;
        for (int j = 0; j < BUDGET && !done; j++) begin
            cyc();
            #1;
            if (!bus_if.oStall) done = 1;
        end
        if (!done) timeout("st_wait");
        cyc();
        bus_if.iReq = 0;
        bus_if.iWE  = 0;
        chk("st_beats", log_addr.size(), 1);
        if (log_addr.size() == 1) begin
            chk("st_addr", log_addr[0], {a[31:2], 2'b00});
            chk("st_we", log_we[0], 1);
            chk("st_wdata", log_wdat[0], d);
        end
    endtask

    task automatic do_flush();
        int busy_n;
        bit done;
        busy_n = 0;
        done   = 0;
        bus_if.iReq   = 0;
        bus_if.iFlush = 1;
        for (int j = 0; j < BUDGET && !done; j++) begin
            cyc();
            bus_if.iFlush = 0;
            bus_if.iWE    = 0;
            bus_if.iReq   = 1'($urandom_range(0, 1));
            bus_if.iAddr  = $urandom & 32'h0000_0FFC;
            #1;
            if (bus_if.oFlushBusy) begin
                busy_n++;
                chk("fl_stall_eq_req", bus_if.oStall, bus_if.iReq);
            end else begin
                done = 1;
            end
        end
        bus_if.iReq = 0;
        if (!done) timeout("fl_wait");
        chk("fl_busy_cycles", busy_n, LINES);
        flush_model();
    endtask

    initial begin
        logic [31:0] a;
        iRSTn = 0;
        bus_if.iReq = 0; bus_if.iWE = 0; bus_if.iAddr = 0; bus_if.iWData = 0;
        bus_if.iFlush = 0; bus_if.iMemAck = 0; bus_if.iMemRData = 0;
        flush_model();
        repeat (3) cyc();
        #1;
        chk("rst_mem_req", bus_if.oMemReq, 0);
        chk("rst_mem_we", bus_if.oMemWE, 0);
        chk("rst_mem_addr", bus_if.oMemAddr, 0);
        chk("rst_mem_wdata", bus_if.oMemWData, 0);
        chk("rst_flush_busy", bus_if.oFlushBusy, 0);
        chk("rst_stall", bus_if.oStall, 0);
        cyc();
        iRSTn = 1;

        // Cold miss, then hit on a neighbouring word.
        do_load(32'h100, 0);
        do_load(32'h104, 0);
        // Conflict on index 0.
        do_load(32'h500, 0);
        do_load(32'h100, 0);
        // Write-through hit, then no-allocate miss.
        do_store(32'h104, 32'hDEAD_BEEF);
        do_load(32'h104, 0);
        do_store(32'h2000, 32'h1234_5678);
        do_load(32'h2000, 0);
        // Flush with lines 0 and 3 populated.
        do_load(32'h130, 0);
        do_load(32'h100, 0);
        do_flush();
        do_load(32'h100, 0);
        do_load(32'h130, 0);
        // Waited memory: each beat acked after 3 idle cycles.
        ack_delay = 3;
        do_load(32'h740, 0);
        chk("wait_req_cycles", req_cycles, LW * 4);
        ack_delay = 0;

        // Reset in the middle of a refill, after word 1.
        a = 32'h980;
        clear_log();
        bus_if.iReq = 1; bus_if.iWE = 0; bus_if.iAddr = a;
        begin
            bit got;
            got = 0;
            for (int j = 0; j < BUDGET && !got; j++) begin
                cyc();
                if (log_addr.size() == 2) got = 1;
            end
            if (!got) timeout("rst_mid_wait");
        end
        iRSTn = 0;
        #1;
        chk("rst_mid_mem_req", bus_if.oMemReq, 0);
        chk("rst_mid_busy", bus_if.oFlushBusy, 0);
        bus_if.iReq = 0;
        cyc();
        cyc();
        iRSTn = 1;
        flush_model();
        exp_hits = 0;
        exp_miss = 0;
        do_load(a, 0);

        // Deferred flush during a refill, then flush together with a request.
        do_load(32'hA00, 2);
        do_load(32'hA04, 0);
        do_load(32'hA08, 1);

        // Random traffic over a few conflicting lines.
        for (int n = 0; n < 40; n++) begin
            int op;
            a = (32'h40 + $urandom_range(0, 2)) << 8;
            a = a | (32'($urandom_range(0, 3)) << 4) | (32'($urandom_range(0, LW - 1)) << 2);
            ack_delay = $urandom_range(0, 2);
            op = $urandom_range(0, 9);
            if (op < 5)      do_load(a, 0);
            else if (op < 8) do_store(a, $urandom);
            else if (op < 9) do_load(a, 1);
            else             do_flush();
        end
        ack_delay = 0;

`ifdef CACHE_STATS_EN
        chk("stat_hits", bus_if.oHitCount, 32'(exp_hits));
        chk("stat_miss", bus_if.oMissCount, 32'(exp_miss));
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end
endmodule
